// File: rtl/imm_pkg.sv
// imm_pkg: shared widths, FSM states and pixel beat type for the imm pixel streamer
package imm_pkg;
  localparam int PIX_W = 12;
  localparam int ROW_W = 9;
  localparam int COL_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic [PIX_W-1:0] pixel;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
  } beat_t;
endpackage

// File: rtl/imm_skid_buf.sv
// imm_skid_buf: registered output stage backed by a 2-entry skid store; o_occ counts the store only
module imm_skid_buf #(
  parameter int W = 29
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready,
  output logic [1:0]   o_occ
);
  logic [W-1:0] r_mem [2];
  logic [W-1:0] r_data;
  logic         r_valid, r_rd, r_wr;
  logic [1:0]   r_cnt;
  logic         w_load, w_take, w_direct, w_push;
  // the output register refills from the store first so beat order is kept
  assign w_load   = !r_valid | i_ready;
  assign w_take   = w_load & (r_cnt != 2'd0);
  assign w_direct = w_load & (r_cnt == 2'd0) & i_valid;
  assign w_push   = i_valid & !w_direct;
  assign o_valid  = r_valid;
  assign o_data   = r_data;
  assign o_occ    = r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_load) r_valid <= w_take | i_valid;
      if (w_take) r_data <= r_mem[r_rd];
      else if (w_direct) r_data <= i_data;
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ~r_wr;
      end
      if (w_take) r_rd <= ~r_rd;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_take};
    end
  end
endmodule

// File: rtl/imm_pixel_streamer.sv
// imm_pixel_streamer: raster-walks a frame in synchronous memory and streams pixels with
// coordinates and latched mask offsets over valid/ready
module imm_pixel_streamer
  import imm_pkg::*;
#(
  parameter int IMG_ROWS = 320,
  parameter int IMG_COLS = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ROW_W-1:0]  mask_row_offset_in,
  input  logic [COL_W-1:0]  mask_col_offset_in,
  output logic              busy,
  output logic              frame_done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [PIX_W-1:0]  image_pixel,
  output logic [ROW_W-1:0]  pixel_row,
  output logic [COL_W-1:0]  pixel_col,
  output logic [ROW_W-1:0]  mask_row_offset,
  output logic [COL_W-1:0]  mask_col_offset
);
  state_t            r_state, w_next;
  logic [ROW_W-1:0]  r_row, r_inf_row, r_mrow;
  logic [COL_W-1:0]  r_col, r_inf_col, r_mcol;
  logic [ADDR_W-1:0] r_addr;
  logic              r_inflight, r_done;
  logic [1:0]        w_occ;
  logic              w_start_ok, w_col_wrap, w_last_issue, w_last_pop;
  beat_t             w_in, w_out;
  assign w_start_ok   = (r_state == IDLE) & start;
  assign w_col_wrap   = r_col == COL_W'(IMG_COLS - 1);
  assign w_last_issue = mem_rd_en & w_col_wrap & (r_row == ROW_W'(IMG_ROWS - 1));
  // beats leave strictly in raster order, so the final coordinate marks the last pixel
  assign w_last_pop   = pix_valid & pix_ready & (r_state == DRAIN) &
                        (w_out.row == ROW_W'(IMG_ROWS - 1)) & (w_out.col == COL_W'(IMG_COLS - 1));
  assign mem_rd_en    = (r_state == RUN) && ((w_occ + {1'b0, r_inflight}) < 2'd2);
  assign mem_addr     = r_addr;
  assign busy         = r_state != IDLE;
  assign frame_done   = r_done;
  assign w_in         = {mem_rd_data, r_inf_row, r_inf_col};
  assign image_pixel  = w_out.pixel;
  assign pixel_row    = w_out.row;
  assign pixel_col    = w_out.col;
  assign mask_row_offset = r_mrow;
  assign mask_col_offset = r_mcol;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && start) w_next = RUN;
    if (r_state == RUN && w_last_issue) w_next = DRAIN;
    if (r_state == DRAIN && w_last_pop) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row      <= '0;
      r_col      <= '0;
      r_addr     <= '0;
      r_mrow     <= '0;
      r_mcol     <= '0;
      r_inflight <= 1'b0;
      r_inf_row  <= '0;
      r_inf_col  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done     <= w_last_pop;
      r_inflight <= mem_rd_en;
      if (mem_rd_en) begin
        r_inf_row <= r_row;
        r_inf_col <= r_col;
      end
      if (w_start_ok) begin
        r_row  <= '0;
        r_col  <= '0;
        r_addr <= '0;
        r_mrow <= mask_row_offset_in;
        r_mcol <= mask_col_offset_in;
      end else if (mem_rd_en) begin
        r_addr <= r_addr + 1'b1;
        r_col  <= w_col_wrap ? '0 : r_col + 1'b1;
        if (w_col_wrap) r_row <= r_row + 1'b1;
      end
    end
  end
  imm_skid_buf #(.W($bits(beat_t))) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (r_inflight),
    .i_data  (w_in),
    .o_valid (pix_valid),
    .o_data  (w_out),
    .i_ready (pix_ready),
    .o_occ   (w_occ)
  );
endmodule

// File: tb/tb_imm_pixel_streamer.sv
// tb_imm_pixel_streamer: scoreboard bench for a 3x4 frame plus a default-size frame run alongside
module tb_imm_pixel_streamer;
  typedef struct packed {logic [11:0] p; logic [8:0] r; logic [7:0] c;} exp_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // small 3x4 instance
  logic rst_n = 1'b0, start = 1'b0, pix_ready = 1'b1;
  logic [8:0] mask_row_offset_in = '0, pixel_row, mask_row_offset;
  logic [7:0] mask_col_offset_in = '0, pixel_col, mask_col_offset;
  logic busy, frame_done, mem_rd_en, pix_valid;
  logic [3:0] mem_addr;
  logic [11:0] mem_rd_data = '0, image_pixel;
  imm_pixel_streamer #(.IMG_ROWS(3), .IMG_COLS(4), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mask_row_offset_in(mask_row_offset_in), .mask_col_offset_in(mask_col_offset_in),
    .busy(busy), .frame_done(frame_done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .image_pixel(image_pixel), .pixel_row(pixel_row), .pixel_col(pixel_col),
    .mask_row_offset(mask_row_offset), .mask_col_offset(mask_col_offset));
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= {8'h0, mem_addr} + 12'h100;
  // default-size instance
  logic rst_n_b = 1'b0, b_start = 1'b0, b_ready = 1'b1;
  logic b_busy, b_done, b_rd_en, b_valid;
  logic [16:0] b_addr;
  logic [11:0] b_rd_data = '0, b_pix;
  logic [8:0] b_row, b_mrow;
  logic [7:0] b_col, b_mcol;
  imm_pixel_streamer dut_big (
    .clk(clk), .rst_n(rst_n_b), .start(b_start),
    .mask_row_offset_in(9'd1), .mask_col_offset_in(8'd2),
    .busy(b_busy), .frame_done(b_done), .mem_rd_en(b_rd_en), .mem_addr(b_addr),
    .mem_rd_data(b_rd_data), .pix_valid(b_valid), .pix_ready(b_ready),
    .image_pixel(b_pix), .pixel_row(b_row), .pixel_col(b_col),
    .mask_row_offset(b_mrow), .mask_col_offset(b_mcol));
  always @(posedge clk) if (b_rd_en) b_rd_data <= b_addr[11:0] + 12'h100;
  // scoreboard state for the small instance
  exp_t q[$];
  logic [8:0] exp_mrow = '0;
  logic [7:0] exp_mcol = '0;
  int beats = 0, done_cnt = 0, issue_idx = 0, outstanding = 0;
  int start_cyc = 0, first_valid_cyc = -1, last_acc_cyc = 0;
  bit check_lat = 0, rand_ready = 0, prev_busy = 0;
  initial forever begin
    @(posedge clk);
    #1 pix_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 0;
      prev_busy = 0;
    end else begin
      if (pix_valid) begin
        if (first_valid_cyc < 0) begin
          first_valid_cyc = cyc;
          if (check_lat) chk("first_valid_latency", cyc - start_cyc, 3);
        end
        if (q.size() == 0) chk("spurious_beat", 1, 0);
        else begin
          chk("beat", {image_pixel, pixel_row, pixel_col}, q[0]);
          chk("offsets", {mask_row_offset, mask_col_offset}, {exp_mrow, exp_mcol});
          if (pix_ready) begin
            void'(q.pop_front());
            beats++;
            last_acc_cyc = cyc;
          end
        end
      end
      if (mem_rd_en) begin
        chk("mem_addr", mem_addr, issue_idx);
        chk("outstanding_at_issue", outstanding <= 2, 1);
        issue_idx++;
      end
      outstanding += int'(mem_rd_en) - int'(pix_valid & pix_ready);
      if (frame_done) begin
        done_cnt++;
        chk("busy_at_done", busy, 0);
        chk("busy_before_done", prev_busy, 1);
        chk("done_after_last", cyc - last_acc_cyc, 1);
        chk("queue_empty_at_done", q.size(), 0);
      end
      prev_busy = busy;
    end
  end
  // default-size monitor: per-beat errors are tallied and checked once at the end
  int b_idx = 0, b_issue = 0, b_bad = 0, b_done_cnt = 0, b_last_acc = 0, b_done_gap = -1;
  int b_last_row = -1, b_last_col = -1, b_last_addr = -1;
  bit big_fin = 0;
  always @(negedge clk) if (rst_n_b) begin
    if (b_valid && b_ready) begin
      if ({b_pix, b_row, b_col} !== {12'(b_idx + 'h100), 9'(b_idx / 240), 8'(b_idx % 240)}) begin
        if (b_bad == 0) $display("FAIL big_beat %0d: got %0h/%0d/%0d", b_idx, b_pix, b_row, b_col);
        b_bad++;
      end
      b_last_row = int'(b_row);
      b_last_col = int'(b_col);
      b_last_acc = cyc;
      b_idx++;
    end
    if (b_rd_en) begin
      if (int'(b_addr) != b_issue) b_bad++;
      b_last_addr = int'(b_addr);
      b_issue++;
    end
    if (b_done) begin
      b_done_cnt++;
      b_done_gap = cyc - b_last_acc;
    end
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n_b = 1'b1;
    @(posedge clk);
    #1 b_start = 1'b1;
    @(posedge clk);
    #1 b_start = 1'b0;
    for (int n = 0; n < 80000 && b_done_cnt == 0; n++) @(posedge clk);
    repeat (3) @(posedge clk);
    big_fin = 1;
  end
  task automatic start_frame(input logic [8:0] ro, input logic [7:0] co);
    @(posedge clk);
    #1;
    start = 1'b1;
    mask_row_offset_in = ro;
    mask_col_offset_in = co;
    exp_mrow = ro;
    exp_mcol = co;
    start_cyc = cyc;
    first_valid_cyc = -1;
    beats = 0;
    done_cnt = 0;
    issue_idx = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        q.push_back('{p: 12'(r * 4 + c + 'h100), r: 9'(r), c: 8'(c)});
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(input string nm, input int maxc);
    for (int n = 0; n < maxc && done_cnt == 0; n++) @(posedge clk);
    repeat (4) @(posedge clk);
    chk({nm, "_done_count"}, done_cnt, 1);
    chk({nm, "_beats"}, beats, 12);
    chk({nm, "_issues"}, issue_idx, 12);
  endtask
  task automatic check_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_frame_done"}, frame_done, 0);
    chk({nm, "_mem_rd_en"}, mem_rd_en, 0);
    chk({nm, "_pix_valid"}, pix_valid, 0);
    chk({nm, "_mem_addr"}, mem_addr, 0);
    chk({nm, "_pixel"}, image_pixel, 0);
    chk({nm, "_row"}, pixel_row, 0);
    chk({nm, "_col"}, pixel_col, 0);
    chk({nm, "_mask_row"}, mask_row_offset, 0);
    chk({nm, "_mask_col"}, mask_col_offset, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    // full frame, no backpressure
    check_lat = 1;
    start_frame(9'($urandom), 8'($urandom));
    wait_done("full", 200);
    chk("contiguous", last_acc_cyc - first_valid_cyc, 11);
    check_lat = 0;
    // backpressure with an ignored mid-frame start
    rand_ready = 1;
    start_frame(9'd5, 8'd7);
    for (int n = 0; n < 300 && beats < 4; n++) @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b1;
    mask_row_offset_in = 9'd9;
    mask_col_offset_in = 8'd3;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_ignored_start", busy, 1);
    wait_done("backpressure", 400);
    chk("held_offsets", {mask_row_offset, mask_col_offset}, {9'd5, 8'd7});
    // reset in the middle of a frame
    start_frame(9'($urandom), 8'($urandom));
    for (int n = 0; n < 300 && beats < 5; n++) @(posedge clk);
    chk("beats_before_reset", beats >= 5, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midreset");
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    start_frame(9'($urandom), 8'($urandom));
    wait_done("restart", 400);
    rand_ready = 0;
    // default-size frame running alongside
    for (int n = 0; n < 90000 && !big_fin; n++) @(posedge clk);
    chk("big_finished", big_fin, 1);
    chk("big_errors", b_bad, 0);
    chk("big_beats", b_idx, 76800);
    chk("big_last_row", b_last_row, 319);
    chk("big_last_col", b_last_col, 239);
    chk("big_last_addr", b_last_addr, 'h12BFF);
    chk("big_done_count", b_done_cnt, 1);
    chk("big_done_follows_last", b_done_gap, 1);
    chk("big_busy_after", b_busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
